ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
Instruction fetch front end that replaces the direct PC-to-IM path with a decoupled prefetch stage. It issues requests to a variable-latency instruction memory and buffers the returned {pc_plus, instr} pairs in a small FIFO. The FIFO head feeds the IF/ID register directly upstream of the pipelined datapath. The block honours IF-stage stalls from the hazard unit and branch/jump redirects resolved in ID.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
redirect  input  1  taken branch/jump from ID (PCSrc|Jump); flush and refetch
redirect_pc  input  32  target address (pc_br or pc_j)
stall  input  1  IF/ID hold (inverse of IFWrite); blocks pop
imem_req  output  1  fetch request, level
imem_addr  output  32  fetch address, word aligned
imem_ack  input  1  transaction completes on edge where imem_req&imem_ack
imem_rdata  input  32  instruction, valid when imem_ack
inst_valid  output  1  FIFO head valid
inst_out  output  32  head instruction; 32'h0 when !inst_valid
pc_plus_out  output  32  head address+4

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC, FIFO empty, state=RUN, imem_req=0, inst_valid=0, inst_out=0, pc_plus_out=0.
- Single outstanding request; imem_addr and imem_req held stable while a request is pending.
- States:
  - RUN: no request pending. Assert imem_req with imem_addr=fetch_pc when count+0 < DEPTH; go to WAIT the same cycle that req rises.
  - WAIT: request pending. On ack, write {fetch_pc+4, imem_rdata} at tail and set fetch_pc+=4. Then go to RUN, or stay in WAIT and issue the next address if space remains (count+1 < DEPTH).
  - DROP: request pending but stale. Hold req/addr until ack, discard rdata, go to RUN at the redirect target.
- Latency: ack at edge N → entry visible (inst_valid=1) after edge N. No combinational bypass from imem_rdata to inst_out.
- Pop: at an edge with inst_valid & !stall, head advances. Push and pop in the same cycle are both honoured; count is unchanged.
- Full: count==DEPTH → no new request is issued. A request already pending is only issued when space is reserved, so overflow is impossible.
- Empty: inst_valid=0, inst_out=0 (NOP into IF/ID).
- Redirect (priority over push/pop/stall): at the edge, FIFO is emptied (count=0) and fetch_pc=redirect_pc.
  - If a request is pending and its ack is not this edge → DROP.
  - If the ack coincides with the redirect edge → that data is discarded, state=RUN.
  - Otherwise → RUN.
- Redirect while in DROP: fetch_pc is updated to the newest redirect_pc; remain in DROP.
- fetch_pc wraps modulo 2^32. Bits [1:0] of redirect_pc are ignored (forced 0).
- Pointers are log2(DEPTH) bits, wrapping naturally. count is log2(DEPTH)+1 bits.

Optional Feature:
IFQ_STATS_EN: when defined, two extra outputs are added.
- fetch_cnt[31:0]: counts acked and kept fetches.
- drop_cnt[31:0]: counts discarded fetches (DROP acks and redirect-coincident acks).
- Both reset to 0 and wrap.
Without the macro, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset then zero-latency memory (ack same cycle as req), stall=0 → addresses 0,4,8… issued back to back; inst_out sequence matches memory; pc_plus_out=4,8,12.
2. stall held high, 1-cycle ack → after 4 fetches count=4, imem_req=0, head stays addr 0 instr. Release stall → head advances one per cycle and fetching resumes.
3. 3-cycle ack latency with a request to 0x10 pending; redirect to 0x40 → FIFO empty next cycle, req held at 0x10 until ack, data dropped, next req addr=0x40, first inst_valid entry pc_plus_out=0x44.
4. Redirect coincident with ack of 0x8 → 0x8 data never appears at inst_out; next request=redirect_pc.
5. Two redirects (0x100 then 0x200) while in DROP → only 0x200 is fetched afterwards. With IFQ_STATS_EN, drop_cnt=1.
6. Assert rst mid-WAIT → outputs return to reset values immediately (asynchronous). After release, first imem_addr=RESET_PC.

Source files
------------

// File: rtl/ifetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ifetch_queue: decoupled instruction prefetch queue feeding IF/ID.        |
// | Optional IFQ_STATS_EN adds fetch_cnt/drop_cnt outputs.  Rev 1.0          |
// +--------------------------------------------------------------------------+
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_plus_out
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] drop_cnt
`endif
);

  localparam int unsigned    AW      = $clog2(DEPTH);
  localparam int unsigned    CW      = AW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pcp_q   [DEPTH];

  logic          w_ack;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_pc_inc;

  assign w_ack    = req_q & imem_ack;
  assign w_pc_inc = pc_q + 32'd4;
  assign w_pop    = (count_q != '0) & ~stall & ~redirect;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    w_push  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (count_q < DEPTH_C) begin
          state_d = ST_WAIT;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
      end
      ST_WAIT: begin
        if (w_ack) begin
          w_push = 1'b1;
          pc_d   = w_pc_inc;
          // Chain the next fetch only if a slot is still free after this push.
          if ((count_q + CW'(1)) < DEPTH_C) begin
            addr_d = w_pc_inc;
          end else begin
            state_d = ST_RUN;
            req_d   = 1'b0;
          end
        end
      end
      ST_DROP: begin
        if (w_ack) begin
          state_d = ST_RUN;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_RUN;
        req_d   = 1'b0;
      end
    endcase

    if (redirect) begin
      w_push = 1'b0;
      pc_d   = redirect_pc & 32'hFFFF_FFFC;
      addr_d = addr_q;
      // A still-outstanding request must complete on the bus before refetching.
      if ((state_q != ST_RUN) && !w_ack) begin
        state_d = ST_DROP;
        req_d   = req_q;
      end else begin
        state_d = ST_RUN;
        req_d   = 1'b0;
      end
    end
  end

  assign count_d  = redirect ? '0 : (count_q + CW'(w_push) - CW'(w_pop));
  assign wr_ptr_d = redirect ? '0 : (wr_ptr_q + AW'(w_push));
  assign rd_ptr_d = redirect ? '0 : (rd_ptr_q + AW'(w_pop));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      instr_q[wr_ptr_q] <= imem_rdata;
      pcp_q[wr_ptr_q]   <= w_pc_inc;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign inst_valid  = (count_q != '0);
  assign inst_out    = inst_valid ? instr_q[rd_ptr_q] : 32'h0;
  assign pc_plus_out = inst_valid ? pcp_q[rd_ptr_q]   : 32'h0;

`ifdef IFQ_STATS_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] drop_cnt_q;
  logic        w_drop;

  // Stale completions: any ack while in DROP, or an ack landing on a redirect edge.
  assign w_drop = w_ack & ((state_q == ST_DROP) | redirect);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= 32'h0;
      drop_cnt_q  <= 32'h0;
    end else begin
      if (w_push) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (w_drop) drop_cnt_q  <= drop_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// tb_ifetch_queue: vector table, directed corner sequences and a randomized run
// against a queue-based model of the prefetch queue.
`timescale 1ns/1ps
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_plus_out;
`ifdef IFQ_STATS_EN
  logic [31:0] fetch_cnt;
  logic [31:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_out(inst_out), .pc_plus_out(pc_plus_out)
`ifdef IFQ_STATS_EN
    , .fetch_cnt(fetch_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pcp;
    logic [31:0] ins;
  } ent_t;

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pcp;
  } vec_t;

  // Reference model: outstanding-request flags, fetch pointer, entry queue.
  ent_t        q[$];
  bit          m_pend;
  bit          m_stale;
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  int          m_fetches;
  int          m_drops;
  int          age;
  int          lat;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1357};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pend = 1'b0; m_stale = 1'b0;
    m_pc = RESET_PC; m_addr = RESET_PC;
    m_fetches = 0; m_drops = 0; age = 0;
  endtask

  task automatic check_all();
    chk("imem_req", 32'(imem_req), 32'(m_pend));
    if (m_pend) chk("imem_addr", imem_addr, m_addr);
    chk("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
    chk("inst_out", inst_out, (q.size() != 0) ? q[0].ins : 32'h0);
    chk("pc_plus_out", pc_plus_out, (q.size() != 0) ? q[0].pcp : 32'h0);
`ifdef IFQ_STATS_EN
    chk("fetch_cnt", fetch_cnt, 32'(m_fetches));
    chk("drop_cnt", drop_cnt, 32'(m_drops));
`endif
  endtask

  // Called at a negedge: drive inputs, advance the model, clock once, compare.
  task automatic step(input bit rd, input logic [31:0] rpc, input bit st);
    bit ack;
    bit ackd;
    int cnt;
    redirect = rd; redirect_pc = rpc; stall = st;
    if (lat < 0) ack = imem_req && ($urandom_range(0, 1) == 1);
    else         ack = imem_req && (age >= lat);
    imem_ack   = ack;
    imem_rdata = ack ? memf(imem_addr) : $urandom();

    ackd = m_pend && ack;
    cnt  = q.size();
    if (rd) begin
      q.delete();
      m_pc = {rpc[31:2], 2'b00};
      if (ackd) begin
        m_drops++; m_pend = 1'b0; m_stale = 1'b0;
      end else if (m_pend) begin
        m_stale = 1'b1;
      end
    end else begin
      if (cnt > 0 && !st) void'(q.pop_front());
      if (ackd && m_stale) begin
        m_drops++; m_pend = 1'b0; m_stale = 1'b0;
      end else if (ackd) begin
        q.push_back('{pcp: m_pc + 32'd4, ins: memf(m_addr)});
        m_fetches++;
        m_pc = m_pc + 32'd4;
        if (cnt + 1 < DEPTH) m_addr = m_pc;
        else                 m_pend = 1'b0;
      end else if (!m_pend && cnt < DEPTH) begin
        m_pend = 1'b1; m_addr = m_pc;
      end
    end

    if (imem_req && ack) age = 0;
    else if (imem_req)   age++;
    else                 age = 0;

    @(posedge clk);
    @(negedge clk);
    redirect = 1'b0; imem_ack = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; redirect = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_pend(input logic [31:0] a, input bit st, input int bound);
    bit found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (m_pend && !m_stale && m_addr == a) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 32'h0, st);
    end
    chk("reach_req_addr", 32'(found), 32'd1);
  endtask

  vec_t tbl[6];

  initial begin
    bit seen;
    bit bad;
`ifdef IFQ_STATS_EN
    logic [31:0] d0;
`endif
    // Zero-latency memory, no stall: back-to-back fetch 0,4,8,...
    tbl[0] = '{stall: 1'b0, req: 1'b0, addr: 32'h00, valid: 1'b0, pcp: 32'h00};
    tbl[1] = '{stall: 1'b0, req: 1'b1, addr: 32'h00, valid: 1'b0, pcp: 32'h00};
    tbl[2] = '{stall: 1'b0, req: 1'b1, addr: 32'h04, valid: 1'b1, pcp: 32'h04};
    tbl[3] = '{stall: 1'b0, req: 1'b1, addr: 32'h08, valid: 1'b1, pcp: 32'h08};
    tbl[4] = '{stall: 1'b0, req: 1'b1, addr: 32'h0C, valid: 1'b1, pcp: 32'h0C};
    tbl[5] = '{stall: 1'b0, req: 1'b1, addr: 32'h10, valid: 1'b1, pcp: 32'h10};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      chk("tbl_req", 32'(imem_req), 32'(tbl[i].req));
      if (tbl[i].req) chk("tbl_addr", imem_addr, tbl[i].addr);
      chk("tbl_valid", 32'(inst_valid), 32'(tbl[i].valid));
      chk("tbl_pcp", pc_plus_out, tbl[i].pcp);
      chk("tbl_inst", inst_out, tbl[i].valid ? memf(tbl[i].pcp - 32'd4) : 32'h0);
      stall      = tbl[i].stall;
      imem_ack   = imem_req;
      imem_rdata = memf(imem_addr);
      @(posedge clk);
      @(negedge clk);
      imem_ack = 1'b0;
    end

    // Stall fills the queue; fetching stops at full; release drains in order.
    do_reset();
    lat = 1;
    check_all();
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1);
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_valid", 32'(inst_valid), 32'd1);
    chk("full_head_pcp", pc_plus_out, 32'h4);
    chk("full_head_inst", inst_out, memf(32'h0));
    step(1'b0, 32'h0, 1'b0);
    chk("drain_head_pcp", pc_plus_out, 32'h8);
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b0);

    // Redirect while a 3-cycle request to 0x10 is outstanding.
    do_reset();
    lat = 3;
    wait_pend(32'h10, 1'b0, 60);
    step(1'b1, 32'h40, 1'b0);
    chk("drop_valid", 32'(inst_valid), 32'd0);
    chk("drop_req_held", 32'(imem_req), 32'd1);
    chk("drop_addr_held", imem_addr, 32'h10);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 32'h0, 1'b0);
      if (inst_valid) begin
        seen = 1'b1;
        chk("first_after_drop_pcp", pc_plus_out, 32'h44);
      end
    end
    chk("first_after_drop_seen", 32'(seen), 32'd1);

    // Redirect on the same edge as the ack of 0x8.
    do_reset();
    lat = 1;
    wait_pend(32'h8, 1'b0, 40);
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h80, 1'b0);
    chk("coinc_req", 32'(imem_req), 32'd0);
    chk("coinc_valid", 32'(inst_valid), 32'd0);
    step(1'b0, 32'h0, 1'b0);
    chk("coinc_next_req", 32'(imem_req), 32'd1);
    chk("coinc_next_addr", imem_addr, 32'h80);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0);

    // Two redirects while draining a stale request.
    do_reset();
    lat = 4;
    wait_pend(32'h4, 1'b0, 40);
`ifdef IFQ_STATS_EN
    d0 = drop_cnt;
`endif
    step(1'b1, 32'h100, 1'b0);
    step(1'b1, 32'h200, 1'b0);
    bad = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(1'b0, 32'h0, 1'b0);
      if (imem_req && imem_addr == 32'h100) bad = 1'b1;
      if (imem_req && imem_addr == 32'h200) seen = 1'b1;
    end
    chk("dbl_redirect_no_100", 32'(bad), 32'd0);
    chk("dbl_redirect_fetch_200", 32'(seen), 32'd1);
`ifdef IFQ_STATS_EN
    chk("dbl_redirect_drop_cnt", drop_cnt - d0, 32'd1);
`endif

    // Asynchronous reset in the middle of a pending request.
    do_reset();
    lat = 5;
    wait_pend(32'h8, 1'b1, 60);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_req", 32'(imem_req), 32'd0);
    chk("async_rst_valid", 32'(inst_valid), 32'd0);
    chk("async_rst_inst", inst_out, 32'h0);
    chk("async_rst_pcp", pc_plus_out, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    check_all();
    step(1'b0, 32'h0, 1'b0);
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, RESET_PC);

    // Randomized traffic, including redirects near the top of the address space.
    do_reset();
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      bit          rd;
      logic [31:0] rpc;
      if (i % 200 == 0) lat = $urandom_range(0, 4) - 1;
      rd  = ($urandom_range(0, 15) == 0);
      rpc = $urandom();
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      step(rd, rpc, ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
